register_file_mp: RTL and testbench
===================================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32: register count, power of two >= 2; AW = clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter NUM_WR, default 2: number of write ports, 1..2.
REQ-005 SHALL have parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-006 SHALL have parameter RESET_INIT, default 1: when 1, register i resets to value i; when 0, to zero.
REQ-007 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port rd_en, input, NUM_RD bits: per-port read request.
REQ-010 SHALL have port rd_addr, input, NUM_RD*AW bits: packed read addresses, port p at [p*AW +: AW].
REQ-011 SHALL have port rd_data, output, NUM_RD*DATA_W bits: registered read data, packed the same way.
REQ-012 SHALL have port rd_busy, output, NUM_RD bits: registered scoreboard status of the register each port read.
REQ-013 SHALL have port wr_en, input, NUM_WR bits: per-port write enable.
REQ-014 SHALL have port wr_addr, input, NUM_WR*AW bits: packed write addresses.
REQ-015 SHALL have port wr_data, input, NUM_WR*DATA_W bits: packed write data.
REQ-016 SHALL have port issue_en, input, 1 bit: marks issue_addr busy (pending producer).
REQ-017 SHALL have port issue_addr, input, AW bits: destination register being issued.
REQ-018 SHALL have port busy_vec, output, NUM_REGS bits: current scoreboard, bit i = register i busy.

Function
REQ-019 SHALL perform writes on the rising edge when wr_en[w]=1; both ports may write in the same cycle.
REQ-020 SHALL, when both write ports target one address in the same cycle, store port 1 data (highest index wins).
REQ-021 SHALL, with ZERO_REG=1, ignore writes to address 0, return 0 on reads of address 0, and never set busy_vec[0].
REQ-022 SHALL register read data with one-cycle latency: rd_en[p] at edge N -> rd_data[p] valid after edge N, held until the next rd_en[p].
REQ-023 SHALL bypass same-cycle writes: a read sampled while wr_en targets the same address returns the written data (REQ-020 priority applies).
REQ-024 SHALL set busy_vec[issue_addr] at the edge where issue_en=1; issuing to an already busy register leaves it busy.
REQ-025 SHALL clear busy_vec[a] at the edge where any write port writes address a.
REQ-026 SHALL keep busy set when issue and write to the same address coincide (new producer wins).
REQ-027 SHALL load rd_busy[p] with busy_vec after that edge's clear/set for the sampled address, i.e. a same-cycle write reads as not busy unless also reissued.
REQ-028 SHALL treat out-of-range addresses as impossible (NUM_REGS power of two); no error output.

Reset
REQ-029 SHALL, while reset_n=0, asynchronously set register i to i (RESET_INIT=1) or 0, rd_data to 0, rd_busy to 0, busy_vec to 0.
REQ-030 SHALL discard any write, read or issue coinciding with reset assertion; first valid operation is the first rising edge with reset_n=1.

Structure
REQ-031 SHALL place DATA_W, NUM_REGS, NUM_RD, NUM_WR defaults and the AW derivation in shared package rf_pkg.
REQ-032 SHALL implement the scoreboard (REQ-024..026) as sub-module rf_scoreboard, instantiated once.

Verification
REQ-033 SHALL verify reset: reset_n=0 mid-run -> reg 5 reads 5, rd_data=0, busy_vec=0 immediately.
REQ-034 SHALL verify dual write collision: wr port0 (7,0xAAAA), port1 (7,0x5555) same edge -> later read of 7 returns 0x5555.
REQ-035 SHALL verify bypass: write (3,0x1234) and read 3 on same edge -> rd_data=0x1234 after that edge.
REQ-036 SHALL verify zero register: write (0,0xFFFF) then read 0 -> rd_data=0, busy_vec[0]=0 after issue to 0.
REQ-037 SHALL verify scoreboard: issue 9 -> busy_vec[9]=1; write 9 plus issue 9 same edge -> stays 1; write 9 alone -> 0, rd_busy of read 9 that edge = 0.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and address-width helper for the multi-port register file
package rf_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int NUM_RD_DEF   = 2;
    localparam int NUM_WR_DEF   = 2;

    function automatic int addr_w(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-producer scoreboard: issue sets a register busy, any write clears it
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_WR   = NUM_WR_DEF,
    parameter int ZERO_REG = 1,
    parameter int AW       = addr_w(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_addr,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    output logic [NUM_REGS-1:0]  busy_vec,
    output logic [NUM_REGS-1:0]  busy_next
);

    // Set is applied after clear so a coinciding issue keeps the register busy.
    always_comb begin
        busy_next = busy_vec;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                busy_next[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (issue_en) begin
            busy_next[issue_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_next;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with write bypass and issue scoreboard
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int NUM_RD     = NUM_RD_DEF,
    parameter int NUM_WR     = NUM_WR_DEF,
    parameter int ZERO_REG   = 1,
    parameter int RESET_INIT = 1,
    parameter int AW         = addr_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_addr,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [DATA_W-1:0]   rd_val [NUM_RD];
    logic [NUM_RD-1:0]   rd_busy_nxt;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_WR-1:0]   wr_live;

    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            wr_live[w] = wr_en[w] && !((ZERO_REG != 0) && (wr_addr[w*AW +: AW] == '0));
        end
    end

    // Later ports are visited last so the highest-index writer wins a collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (RESET_INIT != 0) ? DATA_W'(i) : '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_live[w]) begin
                    regs[wr_addr[w*AW +: AW]] <= wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_val[p] = regs[rd_addr[p*AW +: AW]];
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_live[w] && (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])) begin
                    rd_val[p] = wr_data[w*DATA_W +: DATA_W];
                end
            end
            if ((ZERO_REG != 0) && (rd_addr[p*AW +: AW] == '0)) begin
                rd_val[p] = '0;
            end
            rd_busy_nxt[p] = busy_next[rd_addr[p*AW +: AW]];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (rd_en[p]) begin
                    rd_data[p*DATA_W +: DATA_W] <= rd_val[p];
                    rd_busy[p]                  <= rd_busy_nxt[p];
                end
            end
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .busy_vec   (busy_vec),
        .busy_next  (busy_next)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - scoreboard bench for register_file_mp with directed vectors
module tb_register_file_mp;

    logic        clk;
    logic        reset_n;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic [31:0] busy_vec;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t q[$];

    register_file_mp dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .busy_vec   (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        rd_en    = '0;
        wr_en    = '0;
        issue_en = 1'b0;
    endtask

    task automatic rd(input int p, input logic [4:0] a, input logic [31:0] d, input logic b);
        exp_t e;
        rd_en[p]          = 1'b1;
        rd_addr[p*5 +: 5] = a;
        e.port = p;
        e.data = d;
        e.busy = b;
        q.push_back(e);
    endtask

    task automatic wr(input int w, input logic [4:0] a, input logic [31:0] d);
        wr_en[w]            = 1'b1;
        wr_addr[w*5 +: 5]   = a;
        wr_data[w*32 +: 32] = d;
    endtask

    task automatic iss(input logic [4:0] a);
        issue_en   = 1'b1;
        issue_addr = a;
    endtask

    task automatic step();
        @(negedge clk);
        clr();
    endtask

    // Monitor: a port presents data one edge after it was enabled.
    logic [1:0] mon_en;
    logic       mon_rs;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            mon_en = rd_en;
            mon_rs = reset_n;
            #1;
            if (mon_rs) begin
                for (int p = 0; p < 2; p++) begin
                    if (mon_en[p]) begin
                        if (q.size() == 0) begin
                            chk("unexpected_read", 64'(p), 64'hFFFF);
                        end else begin
                            e = q.pop_front();
                            chk("rd_port", 64'(p), 64'(e.port));
                            chk($sformatf("rd%0d_data", p), 64'(rd_data[p*32 +: 32]), 64'(e.data));
                            chk($sformatf("rd%0d_busy", p), 64'(rd_busy[p]), 64'(e.busy));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        clk        = 1'b0;
        reset_n    = 1'b0;
        rd_addr    = '0;
        wr_addr    = '0;
        wr_data    = '0;
        issue_addr = '0;
        clr();
        repeat (2) @(negedge clk);
        chk("reset_rd_data", rd_data, 64'h0);
        chk("reset_rd_busy", 64'(rd_busy), 64'h0);
        chk("reset_busy_vec", 64'(busy_vec), 64'h0);
        reset_n = 1'b1;

        rd(0, 5'd5, 32'd5, 1'b0);
        rd(1, 5'd31, 32'd31, 1'b0);
        step();

        // Collision on 7: port 1 wins, and a same-edge read sees port 1 data.
        wr(0, 5'd7, 32'hAAAA);
        wr(1, 5'd7, 32'h5555);
        rd(1, 5'd7, 32'h5555, 1'b0);
        step();

        rd(0, 5'd7, 32'h5555, 1'b0);
        wr(0, 5'd3, 32'h1234);
        rd(1, 5'd3, 32'h1234, 1'b0);
        step();

        step();
        chk("hold_rd0", 64'(rd_data[31:0]), 64'h5555);
        chk("hold_rd1", 64'(rd_data[63:32]), 64'h1234);

        wr(0, 5'd0, 32'hFFFF);
        rd(1, 5'd0, 32'h0, 1'b0);
        step();

        rd(0, 5'd0, 32'h0, 1'b0);
        iss(5'd0);
        step();
        chk("zero_busy_vec", 64'(busy_vec), 64'h0);

        iss(5'd9);
        rd(0, 5'd9, 32'd9, 1'b1);
        step();
        chk("issue9_busy_vec", 64'(busy_vec), 64'(32'h1 << 9));

        wr(0, 5'd9, 32'h99);
        iss(5'd9);
        rd(0, 5'd9, 32'h99, 1'b1);
        step();
        chk("reissue9_busy_vec", 64'(busy_vec), 64'(32'h1 << 9));

        wr(1, 5'd9, 32'h77);
        rd(1, 5'd9, 32'h77, 1'b0);
        step();
        chk("write9_busy_vec", 64'(busy_vec), 64'h0);

        iss(5'd12);
        step();
        iss(5'd13);
        rd(0, 5'd12, 32'd12, 1'b1);
        step();
        chk("busy_12_13", 64'(busy_vec), 64'((32'h1 << 12) | (32'h1 << 13)));

        wr(0, 5'd12, 32'hC);
        wr(1, 5'd13, 32'hD);
        rd(0, 5'd13, 32'hD, 1'b0);
        step();
        chk("clear_12_13", 64'(busy_vec), 64'h0);

        iss(5'd20);
        rd(0, 5'd20, 32'd20, 1'b1);
        step();
        chk("busy_20", 64'(busy_vec), 64'(32'h1 << 20));

        // Mid-run asynchronous reset: outputs clear immediately, writes under reset are dropped.
        reset_n = 1'b0;
        #1;
        chk("midrst_rd_data", rd_data, 64'h0);
        chk("midrst_rd_busy", 64'(rd_busy), 64'h0);
        chk("midrst_busy_vec", 64'(busy_vec), 64'h0);
        wr(0, 5'd5, 32'hDEAD);
        wr(1, 5'd7, 32'hBEEF);
        iss(5'd6);
        step();
        chk("inrst_busy_vec", 64'(busy_vec), 64'h0);
        reset_n = 1'b1;

        rd(0, 5'd5, 32'd5, 1'b0);
        rd(1, 5'd7, 32'd7, 1'b0);
        step();
        chk("postrst_busy_vec", 64'(busy_vec), 64'h0);
        step();

        chk("queue_empty", 64'(q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
